// File: rtl/eth_stats_collector_mc.sv
// Multi-channel Ethernet statistics snapshot collector with an AXI4-Lite register window.
// Define ESC_PERIODIC_EN to build the SAMPLE_PERIOD timer; otherwise only the change trigger exists.

module eth_stats_collector_mc #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 64,
  parameter int DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [11:0]             s_axi_awaddr,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [31:0]             s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [11:0]             s_axi_araddr,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [31:0]             s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic                    enable,
  output logic                    srst,
  input  logic [63:0]             current_time,
  input  logic [NUM_CH*CNT_W-1:0] tx_bytes,
  input  logic [NUM_CH*CNT_W-1:0] tx_good,
  input  logic [NUM_CH*CNT_W-1:0] tx_bad,
  input  logic [NUM_CH*CNT_W-1:0] rx_bytes,
  input  logic [NUM_CH*CNT_W-1:0] rx_good,
  input  logic [NUM_CH*CNT_W-1:0] rx_bad
);

  localparam int NSLOT  = NUM_CH * 6;
  localparam int SNAP_W = NSLOT * CNT_W;
  localparam int AW     = $clog2(DEPTH);

  localparam logic [3:0] SEL_CFG    = 4'd0;
  localparam logic [3:0] SEL_STATUS = 4'd1;
  localparam logic [3:0] SEL_POP    = 4'd2;
  localparam logic [3:0] SEL_OVF    = 4'd3;
  localparam logic [3:0] SEL_PER    = 4'd4;
  localparam logic [3:0] SEL_TLO    = 4'd5;
  localparam logic [3:0] SEL_THI    = 4'd6;
  localparam logic [3:0] SEL_ENT    = 4'd7;
  localparam logic [3:0] SEL_NONE   = 4'd8;

  function automatic logic [3:0] decode(input logic [11:0] a);
    case (a[11:2])
      10'h000: decode = SEL_CFG;
      10'h001: decode = SEL_STATUS;
      10'h002: decode = SEL_POP;
      10'h003: decode = SEL_OVF;
      10'h004: decode = SEL_PER;
      10'h040: decode = SEL_TLO;
      10'h041: decode = SEL_THI;
      default: decode = ((a >= 12'h108) && ((12'(a - 12'h108) >> 3) < 12'(NSLOT)))
                        ? SEL_ENT : SEL_NONE;
    endcase
  endfunction

  logic              overwrite;
  logic [SNAP_W-1:0] snap;
  logic [SNAP_W-1:0] shadow;
  logic [63:0]       mem_time [DEPTH];
  logic [SNAP_W-1:0] mem_snap [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [AW:0]       count;
  logic [31:0]       ovf_cnt;
  logic              ovf_flag;
  logic              empty;
  logic              full;
  logic              trig;
  logic              period_hit;
  logic [31:0]       period_rd;
  logic              mem_we;
  logic [3:0]        wsel;
  logic [3:0]        rsel;
  logic              wr_hs;
  logic              rd_hs;
  logic              do_pop;
  logic              wr_err;
  logic              rd_err;
  logic [63:0]       head_time;
  logic [SNAP_W-1:0] head_snap;
  logic [11:0]       roff;
  logic [63:0]       ent64;
  logic [31:0]       status;
  logic [31:0]       rd_val;

  // Snapshot slot order inside a channel: tx_bytes, tx_good, tx_bad, rx_bytes, rx_good, rx_bad
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign snap[(c*6+0)*CNT_W +: CNT_W] = tx_bytes[c*CNT_W +: CNT_W];
    assign snap[(c*6+1)*CNT_W +: CNT_W] = tx_good[c*CNT_W +: CNT_W];
    assign snap[(c*6+2)*CNT_W +: CNT_W] = tx_bad[c*CNT_W +: CNT_W];
    assign snap[(c*6+3)*CNT_W +: CNT_W] = rx_bytes[c*CNT_W +: CNT_W];
    assign snap[(c*6+4)*CNT_W +: CNT_W] = rx_good[c*CNT_W +: CNT_W];
    assign snap[(c*6+5)*CNT_W +: CNT_W] = rx_bad[c*CNT_W +: CNT_W];
  end

  assign wsel   = decode(s_axi_awaddr);
  assign rsel   = decode(s_axi_araddr);
  assign wr_hs  = s_axi_awready & s_axi_awvalid & s_axi_wvalid;
  assign rd_hs  = s_axi_arready & s_axi_arvalid;
  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign do_pop = wr_hs & (wsel == SEL_POP) & ~empty;
  assign wr_err = (wsel == SEL_NONE) | ((wsel == SEL_POP) & empty);
  assign rd_err = (rsel == SEL_NONE);
  assign trig   = enable & ((snap != shadow) | period_hit);
  assign mem_we = trig & (~full | do_pop | overwrite);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable    <= 1'b0;
      srst      <= 1'b0;
      overwrite <= 1'b0;
    end else if (wr_hs && (wsel == SEL_CFG) && s_axi_wstrb[0]) begin
      enable    <= s_axi_wdata[0] & ~s_axi_wdata[1];
      srst      <= s_axi_wdata[1];
      overwrite <= s_axi_wdata[2];
    end
  end

`ifdef ESC_PERIODIC_EN
  logic [31:0] sample_period;
  logic [31:0] timer;
  logic        per_wr;

  assign per_wr = wr_hs & (wsel == SEL_PER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_period <= '0;
    end else if (per_wr) begin
      for (int b = 0; b < 4; b++)
        if (s_axi_wstrb[b]) sample_period[b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
    end
  end

  // Timer counts 0..P-1 while enabled; a write of SAMPLE_PERIOD restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (srst || !enable || per_wr || (timer == sample_period - 32'd1)) begin
      timer <= '0;
    end else begin
      timer <= timer + 32'd1;
    end
  end

  assign period_hit = enable & (sample_period != '0) & (timer == sample_period - 32'd1);
  assign period_rd  = sample_period;
`else
  assign period_hit = 1'b0;
  assign period_rd  = '0;
`endif

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_time[wr_ptr] <= current_time;
      mem_snap[wr_ptr] <= snap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      shadow   <= '0;
      ovf_cnt  <= '0;
      ovf_flag <= 1'b0;
    end else if (srst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      shadow   <= '0;
      ovf_cnt  <= '0;
      ovf_flag <= 1'b0;
    end else begin
      if (rd_hs && (rsel == SEL_STATUS)) ovf_flag <= 1'b0;
      // Shadows follow every trigger, even a dropped one, so a held change fires only once
      if (trig) shadow <= snap;
      if (trig && (!full || do_pop)) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        else        count  <= count + 1'b1;
      end else if (trig) begin
        if (overwrite) begin
          wr_ptr <= wr_ptr + 1'b1;
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + 32'd1;
        ovf_flag <= 1'b1;
      end else if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end
    end
  end

  assign head_time = mem_time[rd_ptr];
  assign head_snap = mem_snap[rd_ptr];
  assign roff      = s_axi_araddr - 12'h108;

  always_comb begin
    ent64 = '0;
    for (int s = 0; s < NSLOT; s++)
      if (roff[11:3] == 9'(s)) ent64[CNT_W-1:0] = head_snap[s*CNT_W +: CNT_W];
    status         = '0;
    status[AW:0]   = count;
    status[31]     = ovf_flag;
    rd_val         = '0;
    case (rsel)
      SEL_CFG:    rd_val = {29'b0, overwrite, srst, enable};
      SEL_STATUS: rd_val = status;
      SEL_OVF:    rd_val = ovf_cnt;
      SEL_PER:    rd_val = period_rd;
      SEL_TLO:    rd_val = empty ? 32'h0 : head_time[31:0];
      SEL_THI:    rd_val = empty ? 32'h0 : head_time[63:32];
      SEL_ENT:    rd_val = empty ? 32'h0 : (roff[2] ? ent64[63:32] : ent64[31:0]);
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= 2'b00;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= 2'b00;
      s_axi_rdata   <= '0;
    end else begin
      s_axi_awready <= s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~s_axi_awready;
      s_axi_wready  <= s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~s_axi_awready;
      if (wr_hs) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_err ? 2'b10 : 2'b00;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
      s_axi_arready <= s_axi_arvalid & ~s_axi_rvalid & ~s_axi_arready;
      if (rd_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rresp  <= rd_err ? 2'b10 : 2'b00;
        s_axi_rdata  <= rd_err ? 32'h0 : rd_val;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0],
                         s_axi_wdata, s_axi_wstrb, roff[1:0]};

endmodule

// File: tb/tb_eth_stats_collector_mc.sv
// Scoreboard bench for eth_stats_collector_mc: AXI responses are queued by the stimulus
// and checked by an independent monitor when bvalid/rvalid appear.

module tb_eth_stats_collector_mc;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 32;
  localparam int DEPTH  = 4;

  logic                    clk;
  logic                    rst;
  logic [11:0]             s_axi_awaddr;
  logic [2:0]              s_axi_awprot;
  logic                    s_axi_awvalid;
  logic                    s_axi_awready;
  logic [31:0]             s_axi_wdata;
  logic [3:0]              s_axi_wstrb;
  logic                    s_axi_wvalid;
  logic                    s_axi_wready;
  logic [1:0]              s_axi_bresp;
  logic                    s_axi_bvalid;
  logic                    s_axi_bready;
  logic [11:0]             s_axi_araddr;
  logic [2:0]              s_axi_arprot;
  logic                    s_axi_arvalid;
  logic                    s_axi_arready;
  logic [31:0]             s_axi_rdata;
  logic [1:0]              s_axi_rresp;
  logic                    s_axi_rvalid;
  logic                    s_axi_rready;
  logic                    enable;
  logic                    srst;
  logic [63:0]             current_time;
  logic [NUM_CH*CNT_W-1:0] tx_bytes, tx_good, tx_bad, rx_bytes, rx_good, rx_bad;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [31:0] mask;
    logic [1:0]  resp;
  } exp_t;

  exp_t rq[$];
  exp_t wq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [63:0] tstamp;

  eth_stats_collector_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .enable(enable), .srst(srst), .current_time(current_time),
    .tx_bytes(tx_bytes), .tx_good(tx_good), .tx_bad(tx_bad),
    .rx_bytes(rx_bytes), .rx_good(rx_good), .rx_bad(rx_bad)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    current_time = 64'h0000_0001_0000_0000;
    forever begin
      @(posedge clk);
      #1 current_time = current_time + 64'h0000_0001_0000_0003;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Monitor: compares each presented response against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (s_axi_rvalid) begin
        n_tests++;
        if (rq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_r: rdata=%h rresp=%0d with nothing expected", s_axi_rdata, s_axi_rresp);
        end else begin
          e = rq.pop_front();
          if (((s_axi_rdata & e.mask) !== (e.data & e.mask)) || (s_axi_rresp !== e.resp)) begin
            n_fail++;
            $display("FAIL %s: rdata=%h rresp=%0d, expected rdata=%h (mask %h) rresp=%0d",
                     e.name, s_axi_rdata, s_axi_rresp, e.data, e.mask, e.resp);
          end
        end
      end
      if (s_axi_bvalid) begin
        n_tests++;
        if (wq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_b: bresp=%0d with nothing expected", s_axi_bresp);
        end else begin
          e = wq.pop_front();
          if (s_axi_bresp !== e.resp) begin
            n_fail++;
            $display("FAIL %s: bresp=%0d, expected %0d", e.name, s_axi_bresp, e.resp);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: handshake timeout", name);
  endtask

  task automatic axi_write(input string name, input logic [11:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] resp,
                           input bit poke, input logic [31:0] poke_val);
    exp_t e;
    int   k;
    e.name = name; e.data = '0; e.mask = '0; e.resp = resp;
    wq.push_back(e);
    @(negedge clk);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!s_axi_awready && k < 20);
    if (s_axi_awready && poke) rx_bytes[CNT_W +: CNT_W] = poke_val;
    if (!s_axi_awready) begin
      void'(wq.pop_back());
      timeout({name, "_aw"});
    end
    @(posedge clk);
    #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    k = 0;
    while (!s_axi_bvalid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!s_axi_bvalid) timeout({name, "_b"});
  endtask

  task automatic wr(input string name, input logic [11:0] a, input logic [31:0] d,
                    input logic [1:0] resp);
    axi_write(name, a, d, 4'hF, resp, 1'b0, 32'h0);
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] d,
                    input logic [31:0] mask, input logic [1:0] resp);
    exp_t e;
    int   k;
    e.name = name; e.data = d; e.mask = mask; e.resp = resp;
    rq.push_back(e);
    @(negedge clk);
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!s_axi_arready && k < 20);
    if (!s_axi_arready) begin
      void'(rq.pop_back());
      timeout({name, "_ar"});
    end
    @(posedge clk);
    #1;
    s_axi_arvalid = 1'b0;
    k = 0;
    while (!s_axi_rvalid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!s_axi_rvalid) timeout({name, "_r"});
  endtask

  initial begin
    int k;
    rst = 1'b1;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    tx_bytes = '0; tx_good = '0; tx_bad = '0; rx_bytes = '0; rx_good = '0; rx_bad = '0;
    tstamp = '0;
    repeat (3) @(negedge clk);
    check("reset_handshake", {62'b0, s_axi_awready | s_axi_wready | s_axi_arready,
                              s_axi_bvalid | s_axi_rvalid}, 64'h0);
    check("reset_resp_data", {30'b0, s_axi_bresp, s_axi_rresp, s_axi_rdata}, 64'h0);
    rst = 1'b0;
    check("reset_cfg_ports", {62'b0, enable, srst}, 64'h0);

    rd("rst_cfg",    12'h000, 32'h0, 32'hFFFF_FFFF, 2'b00);
    rd("rst_status", 12'h004, 32'h0, 32'hFFFF_FFFF, 2'b00);
    rd("rst_ovf",    12'h00C, 32'h0, 32'hFFFF_FFFF, 2'b00);
    rd("rst_period", 12'h010, 32'h0, 32'hFFFF_FFFF, 2'b00);

    axi_write("cfg_nostrb", 12'h000, 32'h1, 4'h0, 2'b00, 1'b0, 32'h0);
    rd("cfg_nostrb_rd", 12'h000, 32'h0, 32'hFFFF_FFFF, 2'b00);
    check("enable_after_nostrb", {63'b0, enable}, 64'h0);
    axi_write("cfg_enable", 12'h000, 32'h1, 4'h1, 2'b00, 1'b0, 32'h0);
    rd("cfg_enable_rd", 12'h000, 32'h1, 32'hFFFF_FFFF, 2'b00);
    check("enable_port", {63'b0, enable}, 64'h1);

    rd("empty_time_lo", 12'h100, 32'h0, 32'hFFFF_FFFF, 2'b00);
    rd("empty_entry",   12'h110, 32'h0, 32'hFFFF_FFFF, 2'b00);

    rd("unmapped_rd",  12'h020, 32'h0, 32'hFFFF_FFFF, 2'b10);
    rd("past_window",  12'h168, 32'h0, 32'hFFFF_FFFF, 2'b10);
    wr("unmapped_wr",  12'h800, 32'h1, 2'b10);

    // Single change on channel 0 tx_good
    @(negedge clk);
    tx_good[0 +: CNT_W] = 32'd5;
    tstamp = current_time;
    @(negedge clk);
    rd("first_status",  12'h004, 32'h1, 32'hFFFF_FFFF, 2'b00);
    rd("first_time_lo", 12'h100, tstamp[31:0], 32'hFFFF_FFFF, 2'b00);
    rd("first_time_hi", 12'h104, tstamp[63:32], 32'hFFFF_FFFF, 2'b00);
    rd("ch0_tx_good",   12'h110, 32'd5, 32'hFFFF_FFFF, 2'b00);
    rd("ch0_tx_good_hi",12'h114, 32'd0, 32'hFFFF_FFFF, 2'b00);
    rd("ch0_tx_bad",    12'h118, 32'd0, 32'hFFFF_FFFF, 2'b00);
    rd("last_slot_hi",  12'h164, 32'd0, 32'hFFFF_FFFF, 2'b00);

    wr("pop_one", 12'h008, 32'h0, 2'b00);
    rd("after_pop_status", 12'h004, 32'h0, 32'hFFFF_FFFF, 2'b00);
    wr("pop_empty", 12'h008, 32'h0, 2'b10);
    rd("pop_empty_status", 12'h004, 32'h0, 32'hFFFF_FFFF, 2'b00);

    // Six distinct changes into a 4-deep FIFO, overwrite=0
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      rx_bytes[CNT_W +: CNT_W] = 32'(i);
    end
    @(negedge clk);
    rd("drop_status",   12'h004, 32'h8000_0004, 32'hFFFF_FFFF, 2'b00);
    rd("drop_status2",  12'h004, 32'h0000_0004, 32'hFFFF_FFFF, 2'b00);
    rd("drop_ovf",      12'h00C, 32'd2, 32'hFFFF_FFFF, 2'b00);
    rd("drop_head_rx1", 12'h150, 32'd1, 32'hFFFF_FFFF, 2'b00);
    rd("drop_head_txg", 12'h110, 32'd5, 32'hFFFF_FFFF, 2'b00);

    // POP on a full FIFO in the same cycle as a new change
    axi_write("pop_push_full", 12'h008, 32'h0, 4'hF, 2'b00, 1'b1, 32'd7);
    rd("pp_status", 12'h004, 32'h4, 32'hFFFF_FFFF, 2'b00);
    rd("pp_ovf",    12'h00C, 32'd2, 32'hFFFF_FFFF, 2'b00);
    rd("pp_head",   12'h150, 32'd2, 32'hFFFF_FFFF, 2'b00);

    // Soft reset with entries present
    wr("srst_on", 12'h000, 32'h2, 2'b00);
    check("srst_port_on", {62'b0, srst, enable}, 64'h2);
    rd("srst_status", 12'h004, 32'h0, 32'hFFFF_FFFF, 2'b00);
    rd("srst_ovf",    12'h00C, 32'h0, 32'hFFFF_FFFF, 2'b00);
    wr("srst_en_try", 12'h000, 32'h3, 2'b00);
    check("srst_holds_enable", {63'b0, enable}, 64'h0);
    rd("srst_cfg_rd", 12'h000, 32'h2, 32'hFFFF_FFFF, 2'b00);
    @(negedge clk);
    tx_good = '0;
    rx_bytes = '0;
    wr("srst_off", 12'h000, 32'h0, 2'b00);
    check("srst_port_off", {63'b0, srst}, 64'h0);

    // Overwrite mode: same six-change pattern
    wr("cfg_ovw", 12'h000, 32'h5, 2'b00);
    check("enable_ovw", {63'b0, enable}, 64'h1);
    rd("ovw_idle_status", 12'h004, 32'h0, 32'hFFFF_FFFF, 2'b00);
    for (int i = 11; i <= 16; i++) begin
      @(negedge clk);
      rx_bytes[CNT_W +: CNT_W] = 32'(i);
    end
    @(negedge clk);
    rd("ovw_status",   12'h004, 32'h4, 32'h0000_FFFF, 2'b00);
    rd("ovw_ovf",      12'h00C, 32'd2, 32'hFFFF_FFFF, 2'b00);
    rd("ovw_head_rx1", 12'h150, 32'd13, 32'hFFFF_FFFF, 2'b00);
    rd("ovw_head_txg", 12'h110, 32'd0, 32'hFFFF_FFFF, 2'b00);

    // Periodic trigger with constant counters
    wr("per_srst_on", 12'h000, 32'h2, 2'b00);
    @(negedge clk);
    rx_bytes = '0;
    wr("per_srst_off", 12'h000, 32'h0, 2'b00);
    wr("per_set", 12'h010, 32'd8, 2'b00);
`ifdef ESC_PERIODIC_EN
    rd("per_rd", 12'h010, 32'd8, 32'hFFFF_FFFF, 2'b00);
`else
    rd("per_rd", 12'h010, 32'd0, 32'hFFFF_FFFF, 2'b00);
`endif
    wr("per_enable", 12'h000, 32'h1, 2'b00);
    repeat (34) @(negedge clk);
`ifdef ESC_PERIODIC_EN
    rd("per_status", 12'h004, 32'h4, 32'h0000_FFFF, 2'b00);
`else
    rd("per_status", 12'h004, 32'h0, 32'h0000_FFFF, 2'b00);
`endif

    k = 0;
    while ((rq.size() != 0 || wq.size() != 0) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("queues_drained", 64'(rq.size() + wq.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
